// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one single-port bus.
// Data wins in IDLE; every transaction ends in a one-cycle DONE that pulses the winner's ready.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_sel,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        dm_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stallreq_if,
    output logic        stallreq_mem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        if_err_q, if_err_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        dm_ready_q, dm_ready_d;
    logic        dm_err_q, dm_err_d;
    logic [7:0]  wait_q, wait_d;
    logic [7:0]  wait_inc;
    logic        cancel_q, cancel_d;
    logic        cancel_now;

    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_sel      = bus_sel_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign if_rdata     = if_rdata_q;
    assign if_ready     = if_ready_q;
    assign if_err       = if_err_q;
    assign dm_rdata     = dm_rdata_q;
    assign dm_ready     = dm_ready_q;
    assign dm_err       = dm_err_q;
    assign stallreq_if  = if_req && !if_ready_q;
    assign stallreq_mem = dm_req && !dm_ready_q;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = 1'b0;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        if_ready_d  = 1'b0;
        if_err_d    = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        dm_ready_d  = 1'b0;
        dm_err_d    = 1'b0;
        wait_d      = wait_q;
        cancel_d    = cancel_q;
        wait_inc    = wait_q + 8'd1;
        // A flush in the same cycle as the ack still cancels the fetch.
        cancel_now  = cancel_q | flush;

        case (state_q)
            IDLE: begin
                wait_d   = 8'd0;
                cancel_d = 1'b0;
                if (dm_req) begin
                    state_d     = DATA;
                    bus_req_d   = 1'b1;
                    bus_we_d    = dm_we;
                    bus_sel_d   = dm_sel;
                    bus_addr_d  = dm_addr;
                    bus_wdata_d = dm_wdata;
                end else if (if_req && !flush) begin
                    state_d     = FETCH;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = 4'b1111;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = 32'h0;
                end
            end
            FETCH: begin
                cancel_d = cancel_now;
                if (bus_ack) begin
                    state_d = DONE;
                    if (!cancel_now) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus_rdata;
                    end
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == TIMEOUT_CNT) begin
                        state_d = DONE;
                        if (!cancel_now) begin
                            if_ready_d = 1'b1;
                            if_err_d   = 1'b1;
                            if_rdata_d = 32'h0;
                        end
                    end else begin
                        bus_req_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus_ack) begin
                    state_d    = DONE;
                    dm_ready_d = 1'b1;
                    dm_rdata_d = bus_rdata;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == TIMEOUT_CNT) begin
                        state_d    = DONE;
                        dm_ready_d = 1'b1;
                        dm_err_d   = 1'b1;
                        dm_rdata_d = 32'h0;
                    end else begin
                        bus_req_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                cancel_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'h0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            if_ready_q  <= 1'b0;
            if_err_q    <= 1'b0;
            dm_rdata_q  <= 32'h0;
            dm_ready_q  <= 1'b0;
            dm_err_q    <= 1'b0;
            wait_q      <= 8'd0;
            cancel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_ready_q  <= if_ready_d;
            if_err_q    <= if_err_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_ready_q  <= dm_ready_d;
            dm_err_q    <= dm_err_d;
            wait_q      <= wait_d;
            cancel_q    <= cancel_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions, hand-written corner sequences,
// then a randomized stream checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int TIMEOUT = 255;
    localparam int NEVER   = 1000;

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          k;
        logic [31:0] ack_data;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic        exp_err;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_err;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [3:0]  dm_sel = 4'h0;
    logic [31:0] dm_addr = 32'h0;
    logic [31:0] dm_wdata = 32'h0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        dm_err;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;
    logic        stallreq_if;
    logic        stallreq_mem;

    int total = 0;
    int bad = 0;
    logic [31:0] mdl_if_rd = 32'h0;
    logic [31:0] mdl_dm_rd = 32'h0;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_err(dm_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bus_req"}, 32'(bus_req), 0);
        chk({tag, "_if_ready"}, 32'(if_ready), 0);
        chk({tag, "_dm_ready"}, 32'(dm_ready), 0);
        chk({tag, "_if_err"}, 32'(if_err), 0);
        chk({tag, "_dm_err"}, 32'(dm_err), 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_dm_rdata"}, dm_rdata, 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_wdata"}, bus_wdata, 0);
        chk({tag, "_bus_sel"}, 32'(bus_sel), 0);
        chk({tag, "_bus_we"}, 32'(bus_we), 0);
    endtask

    // Transaction-level expectation: ack at bus cycle k completes k+2 cycles after the
    // request; no ack within TIMEOUT bus cycles yields an error completion.
    function automatic void model(input txn_t t, output int lat, output logic [31:0] rd,
                                  output logic er);
        if (t.k >= TIMEOUT) begin
            lat = TIMEOUT + 1;
            rd  = 32'h0;
            er  = 1'b1;
        end else begin
            lat = t.k + 2;
            rd  = t.ack_data;
            er  = 1'b0;
        end
    endfunction

    task automatic run_txn(input txn_t t, output int lat, output logic [31:0] rd,
                           output logic er, output logic fields_ok, output logic stall_ok,
                           output logic quiet_ok, output int breq_n);
        logic        got;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic        own_ready, own_err, own_stall, oth_ready, oth_err;
        logic [31:0] own_rd, oth_rd, own_mdl, oth_mdl;
        fields_ok = 1'b1; stall_ok = 1'b1; quiet_ok = 1'b1;
        breq_n = 0; lat = 0; got = 1'b0; rd = 32'h0; er = 1'b0;
        exp_we  = t.is_dm ? t.we : 1'b0;
        exp_sel = t.is_dm ? t.sel : 4'b1111;
        own_mdl = t.is_dm ? mdl_dm_rd : mdl_if_rd;
        oth_mdl = t.is_dm ? mdl_if_rd : mdl_dm_rd;
        if (t.is_dm) begin
            dm_req = 1'b1; dm_we = t.we; dm_sel = t.sel; dm_addr = t.addr; dm_wdata = t.wdata;
        end else begin
            if_req = 1'b1; if_addr = t.addr;
        end
        while (!got && lat < 400) begin
            bus_ack   = bus_req && (lat == t.k + 1);
            bus_rdata = bus_ack ? t.ack_data : $urandom();
            #1;
            own_stall = t.is_dm ? stallreq_mem : stallreq_if;
            own_ready = t.is_dm ? dm_ready : if_ready;
            own_err   = t.is_dm ? dm_err : if_err;
            own_rd    = t.is_dm ? dm_rdata : if_rdata;
            oth_ready = t.is_dm ? if_ready : dm_ready;
            oth_err   = t.is_dm ? if_err : dm_err;
            oth_rd    = t.is_dm ? if_rdata : dm_rdata;
            if (own_stall !== 1'b1) stall_ok = 1'b0;
            if (bus_req === 1'b1) begin
                breq_n++;
                if (bus_we !== exp_we || bus_sel !== exp_sel || bus_addr !== t.addr)
                    fields_ok = 1'b0;
                if (t.is_dm && bus_wdata !== t.wdata) fields_ok = 1'b0;
            end
            if (own_ready !== 1'b0 || own_err !== 1'b0 || own_rd !== own_mdl) quiet_ok = 1'b0;
            if (oth_ready !== 1'b0 || oth_err !== 1'b0 || oth_rd !== oth_mdl) quiet_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
            got = t.is_dm ? dm_ready : if_ready;
        end
        bus_ack = 1'b0;
        if (got) begin
            rd = t.is_dm ? dm_rdata : if_rdata;
            er = t.is_dm ? dm_err : if_err;
            own_stall = t.is_dm ? stallreq_mem : stallreq_if;
            if (own_stall !== 1'b0) stall_ok = 1'b0;
            if (bus_req !== 1'b0) fields_ok = 1'b0;
            oth_ready = t.is_dm ? if_ready : dm_ready;
            if (oth_ready !== 1'b0) quiet_ok = 1'b0;
        end
        dm_req = 1'b0;
        if_req = 1'b0;
        step();
    endtask

    task automatic check_txn(input txn_t t, input int exp_lat, input logic [31:0] exp_rd,
                             input logic exp_err, input string tag);
        int          lat, breq_n;
        logic [31:0] rd;
        logic        er, fields_ok, stall_ok, quiet_ok;
        run_txn(t, lat, rd, er, fields_ok, stall_ok, quiet_ok, breq_n);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, 32'(er), 32'(exp_err));
        chk({tag, "_bus_fields"}, 32'(fields_ok), 1);
        chk({tag, "_bus_req_cycles"}, 32'(breq_n), 32'(exp_lat - 1));
        chk({tag, "_stallreq"}, 32'(stall_ok), 1);
        chk({tag, "_quiet"}, 32'(quiet_ok), 1);
        if (t.is_dm) mdl_dm_rd = exp_rd;
        else mdl_if_rd = exp_rd;
    endtask

    initial begin
        txn_t tbl[7];
        txn_t t;
        int          lat;
        logic [31:0] rd;
        logic        er;
        logic        ok;

        tbl[0] = '{1'b0, 1'b0, 4'hF,    32'hBFC00000, 32'h0,        0,     32'h3C080001, 2,   32'h3C080001, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 4'hF,    32'h80000010, 32'h0,        1,     32'hDEADBEEF, 3,   32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 4'b0011, 32'h80000040, 32'h0000BEEF, 3,     32'h12345678, 5,   32'h12345678, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 4'hF,    32'hBFC00004, 32'h0,        2,     32'h00000000, 4,   32'h00000000, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 4'hF,    32'h80000044, 32'h0,        0,     32'hA5A5A5A5, 2,   32'hA5A5A5A5, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 4'hF,    32'h80000048, 32'h0,        NEVER, 32'h0,        256, 32'h0,        1'b1};
        tbl[6] = '{1'b0, 1'b0, 4'hF,    32'hBFC00008, 32'h0,        NEVER, 32'h0,        256, 32'h0,        1'b1};

        rst = 1'b1;
        step();
        step();
        chk_reset_vals("reset");
        chk("reset_stallreq_if", 32'(stallreq_if), 0);
        chk("reset_stallreq_mem", 32'(stallreq_mem), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++)
            check_txn(tbl[i], tbl[i].exp_lat, tbl[i].exp_rd, tbl[i].exp_err, $sformatf("row%0d", i));

        // Simultaneous requests: data first, then the fetch.
        dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h80000010; dm_wdata = 32'h0;
        if_req = 1'b1; if_addr = 32'hBFC00100;
        #1;
        chk("simul_c0_stall_if", 32'(stallreq_if), 1);
        chk("simul_c0_stall_mem", 32'(stallreq_mem), 1);
        step();
        chk("simul_c1_bus_req", 32'(bus_req), 1);
        chk("simul_c1_bus_addr", bus_addr, 32'h80000010);
        bus_ack = 1'b1; bus_rdata = 32'h11112222;
        #1;
        chk("simul_c1_stall_if", 32'(stallreq_if), 1);
        step();
        bus_ack = 1'b0;
        chk("simul_c2_dm_ready", 32'(dm_ready), 1);
        chk("simul_c2_dm_rdata", dm_rdata, 32'h11112222);
        chk("simul_c2_if_ready", 32'(if_ready), 0);
        chk("simul_c2_stall_if", 32'(stallreq_if), 1);
        dm_req = 1'b0;
        step();
        chk("simul_c3_bus_req", 32'(bus_req), 0);
        chk("simul_c3_stall_if", 32'(stallreq_if), 1);
        step();
        chk("simul_c4_bus_req", 32'(bus_req), 1);
        chk("simul_c4_bus_addr", bus_addr, 32'hBFC00100);
        chk("simul_c4_bus_sel", 32'(bus_sel), 32'hF);
        chk("simul_c4_bus_we", 32'(bus_we), 0);
        chk("simul_c4_stall_if", 32'(stallreq_if), 1);
        bus_ack = 1'b1; bus_rdata = 32'h33334444;
        step();
        bus_ack = 1'b0;
        chk("simul_c5_if_ready", 32'(if_ready), 1);
        chk("simul_c5_if_rdata", if_rdata, 32'h33334444);
        if_req = 1'b0;
        mdl_dm_rd = 32'h11112222;
        mdl_if_rd = 32'h33334444;
        step();

        // Flush during FETCH: the bus cycle finishes but no if_ready is produced.
        if_req = 1'b1; if_addr = 32'hBFC00200;
        step();
        chk("flush_bus_req", 32'(bus_req), 1);
        flush = 1'b1; if_req = 1'b0;
        step();
        flush = 1'b0;
        chk("flush_bus_req_held", 32'(bus_req), 1);
        bus_ack = 1'b1; bus_rdata = 32'h55556666;
        step();
        bus_ack = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (if_ready !== 1'b0 || bus_req !== 1'b0 || if_rdata !== mdl_if_rd) ok = 1'b0;
            step();
        end
        chk("flush_no_if_ready", 32'(ok), 1);
        t = '{1'b0, 1'b0, 4'hF, 32'hBFC00204, 32'h0, 1, 32'h77778888, 0, 32'h0, 1'b0};
        model(t, lat, rd, er);
        check_txn(t, lat, rd, er, "after_flush");

        // Reset during DATA, then a stale ack that must be ignored.
        dm_req = 1'b1; dm_we = 1'b1; dm_sel = 4'hF; dm_addr = 32'h80000020; dm_wdata = 32'hCAFEF00D;
        step();
        chk("rstdata_bus_req", 32'(bus_req), 1);
        step();
        step();
        rst = 1'b1; dm_req = 1'b0;
        step();
        chk_reset_vals("rstdata");
        rst = 1'b0;
        mdl_if_rd = 32'h0;
        mdl_dm_rd = 32'h0;
        bus_ack = 1'b1; bus_rdata = 32'h99999999;
        step();
        bus_ack = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (dm_ready !== 1'b0 || bus_req !== 1'b0 || dm_rdata !== 32'h0) ok = 1'b0;
            step();
        end
        chk("stale_ack_ignored", 32'(ok), 1);

        // Randomized stream against the transaction-level model.
        for (int i = 0; i < 30; i++) begin
            t.is_dm    = 1'($urandom_range(0, 1));
            t.we       = t.is_dm ? 1'($urandom_range(0, 1)) : 1'b0;
            t.sel      = t.is_dm ? 4'($urandom_range(1, 15)) : 4'hF;
            t.addr     = $urandom();
            t.wdata    = t.is_dm ? $urandom() : 32'h0;
            t.k        = ($urandom_range(0, 15) == 0) ? 300 : int'($urandom_range(0, 6));
            t.ack_data = $urandom();
            model(t, lat, rd, er);
            check_txn(t, lat, rd, er, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide the following ports, one per line: name  direction  width  meaning.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush; cancels the instruction fetch
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched word; valid with if_ready
- if_ready  out  1  one-cycle fetch completion pulse
- if_err  out  1  fetch timed out; valid with if_ready
- dm_req  in  1  data request; held until dm_ready
- dm_we  in  1  1 = write, 0 = read
- dm_sel  in  4  byte enables
- dm_addr  in  32  data address
- dm_wdata  in  32  write data
- dm_rdata  out  32  read data; valid with dm_ready
- dm_ready  out  1  one-cycle data completion pulse
- dm_err  out  1  data access timed out; valid with dm_ready
- bus_req  out  1  shared single-port bus request
- bus_we, bus_sel, bus_addr, bus_wdata  out  1/4/32/32  bus command fields
- bus_rdata  in  32  bus read data; valid with bus_ack
- bus_ack  in  1  bus completion
- stallreq_if  out  1  stall request for the fetch stage
- stallreq_mem  out  1  stall request for the memory stage
REQ-002 SHALL use the parameter TIMEOUT, default 255, meaning the maximum number of bus cycles to wait for bus_ack.

Function
REQ-003 SHALL implement the FSM states IDLE, FETCH, DATA and DONE.
REQ-004 In IDLE, dm_req SHALL take priority over if_req: IDLE->DATA if dm_req; else IDLE->FETCH if (if_req && !flush); else stay in IDLE.
REQ-005 On leaving IDLE, SHALL register the bus command fields from the granted requester; for a fetch, bus_we=0 and bus_sel=4'b1111.
REQ-006 bus_req SHALL be 1 exactly while in FETCH or DATA, and the bus command fields SHALL be held stable until the state is exited.
REQ-007 On bus_ack in FETCH or DATA: SHALL latch bus_rdata into the granted requester's rdata, then go to DONE.
REQ-008 DONE SHALL last exactly one cycle and SHALL issue no grant; it pulses the granted requester's ready, then returns to IDLE.
REQ-009 Latency SHALL be as follows.
- Request seen in IDLE at cycle N; bus_req=1 at cycle N+1.
- bus_ack at cycle N+1+k (k>=0); ready=1 at cycle N+2+k.
- Minimum latency from request to ready is 2 cycles.
REQ-010 stallreq_if SHALL equal if_req && !if_ready, and stallreq_mem SHALL equal dm_req && !dm_ready (combinational).
REQ-011 A wait counter (8-bit) SHALL clear on entry to FETCH or DATA and increment on each cycle without bus_ack.
REQ-012 When the wait counter reaches TIMEOUT without bus_ack: SHALL drop bus_req, go to DONE, pulse ready with err=1 and rdata=32'h0.
REQ-013 flush while in FETCH SHALL set a cancel flag; the bus transaction SHALL still complete, and the following DONE SHALL suppress if_ready.
REQ-014 flush SHALL NOT affect DATA transactions.
REQ-015 The cancel flag SHALL clear on return to IDLE.
REQ-016 bus_ack received in IDLE or DONE SHALL be ignored.
REQ-017 if_err and dm_err SHALL be 0 whenever the matching ready is 0.
REQ-018 rdata outputs SHALL hold their last value between ready pulses.

Reset
REQ-019 rst SHALL force the following values at the next clock edge, overriding any transaction in flight.
- State = IDLE.
- bus_req, if_ready, dm_ready, if_err, dm_err = 0.
- if_rdata, dm_rdata, bus_addr, bus_wdata = 32'h0; bus_sel = 4'h0; bus_we = 0.
- Wait counter = 0; cancel flag = 0.
REQ-020 A bus_ack arriving after reset for a transaction aborted by reset SHALL be ignored.

Verification
REQ-021 Fetch with zero wait:
- Stimulus: if_req=1, if_addr=0xBFC00000, bus_ack in the first bus_req cycle with bus_rdata=0x3C080001.
- Response: if_ready at cycle N+2, if_rdata=0x3C080001, stallreq_if=1 for cycles N and N+1.
REQ-022 Simultaneous requests:
- Stimulus: dm_req (read 0x80000010) and if_req raised in the same cycle.
- Response: DATA is granted first; the fetch issues in the cycle after DONE; stallreq_if stays 1 throughout.
REQ-023 Write with 3 wait states:
- Stimulus: dm_we=1, dm_sel=4'b0011, dm_wdata=0x0000BEEF.
- Response: bus fields stable for 4 cycles; dm_ready 1 cycle after bus_ack.
REQ-024 Timeout:
- Stimulus: bus_ack never asserted.
- Response: bus_req drops after 255 cycles; dm_ready=1 with dm_err=1 and dm_rdata=0.
REQ-025 Flush and reset mid-operation:
- Stimulus: flush during FETCH, then bus_ack.
- Response: no if_ready pulse; next fetch proceeds normally.
- Stimulus: rst asserted during DATA.
- Response: all outputs are at their REQ-019 values on the next cycle.
